// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Latency: legal op responds SETTLE+1 cycles after the accept edge; illegal op responds 1 cycle after.
// Backpressure: req<i>_ready is high only in IDLE for the winner; one operation in flight at a time.
module alu_share_ctrl #(
  parameter int WIDTH  = 4,
  parameter int OPW    = 3,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             req0_ready,
  output logic             resp0_valid,
  output logic [WIDTH-1:0] resp0_result,
  output logic             resp0_overflow,
  output logic             resp0_err,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             req1_ready,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp1_result,
  output logic             resp1_overflow,
  output logic             resp1_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic             busy,
  output logic             grant_id
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic [CW-1:0]    cnt;
  logic             winner;
  logic             any_valid;
  logic             accept;
  logic             settle_done;
  logic             sel_legal;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OPW-1:0]   sel_op;
  logic             cap_ovf;

  // Round-robin winner and the winner's operands, decoded straight from the valids.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      winner = ~last_grant;
    end else begin
      winner = req1_valid;
    end
    sel_a     = winner ? req1_a  : req0_a;
    sel_b     = winner ? req1_b  : req0_b;
    sel_op    = winner ? req1_op : req0_op;
    // 010 and 011 are the only holes in the opcode map.
    sel_legal = (sel_op != OPW'(2)) && (sel_op != OPW'(3));
    // Logic ops (MSB set) never report overflow, whatever the ALU says.
    cap_ovf   = alu_overflow & ~alu_op[OPW-1];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; ready is held low while reset is asserted.
  always_comb begin
    state_nxt   = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    accept      = 1'b0;
    settle_done = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_valid && !rst) begin
          accept     = 1'b1;
          req0_ready = ~winner;
          req1_ready = winner;
          state_nxt  = sel_legal ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        if (cnt == CNT_LAST) begin
          settle_done = 1'b1;
          state_nxt   = RESP;
        end
      end
      RESP: begin
        resp0_valid = ~grant_id;
        resp1_valid = grant_id;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping, ALU operand latch and settle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      cnt        <= '0;
    end else if (accept) begin
      last_grant <= winner;
      grant_id   <= winner;
      cnt        <= '0;
      // Illegal ops never reach the ALU, so its inputs keep the previous operation.
      if (sel_legal) begin
        alu_a  <= sel_a;
        alu_b  <= sel_b;
        alu_op <= sel_op;
      end
    end else if (state == ISSUE) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Per-requester response registers; only the granted side is ever written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp0_result   <= '0;
      resp0_overflow <= 1'b0;
      resp0_err      <= 1'b0;
      resp1_result   <= '0;
      resp1_overflow <= 1'b0;
      resp1_err      <= 1'b0;
    end else if (accept && !sel_legal) begin
      if (winner) begin
        resp1_result   <= '0;
        resp1_overflow <= 1'b0;
        resp1_err      <= 1'b1;
      end else begin
        resp0_result   <= '0;
        resp0_overflow <= 1'b0;
        resp0_err      <= 1'b1;
      end
    end else if (settle_done) begin
      if (grant_id) begin
        resp1_result   <= alu_result;
        resp1_overflow <= cap_ovf;
        resp1_err      <= 1'b0;
      end else begin
        resp0_result   <= alu_result;
        resp0_overflow <= cap_ovf;
        resp0_err      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: two instances (SETTLE=1 and SETTLE=3) behind a select.
// Latency: n/a.
// Backpressure: stimulus waits on req<i>_ready with a bounded cycle budget.
module tb_alu_share_ctrl;
  localparam int W  = 4;
  localparam int OW = 3;

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
    logic         ovf;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          use_b = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [OW-1:0] op0 = '0, op1 = '0;

  logic [1:0]    rdy0, rdy1, rv0, rv1, ro0, ro1, re0, re1, bz, gid, aovf;
  logic [W-1:0]  rr0 [2];
  logic [W-1:0]  rr1 [2];
  logic [W-1:0]  aa  [2];
  logic [W-1:0]  ab  [2];
  logic [W-1:0]  ares[2];
  logic [OW-1:0] aop [2];

  // Reference ALU; logic ops deliberately drive overflow high so the controller must mask it.
  function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [OW-1:0] op);
    case (op)
      3'b000:  alu_f = {1'b0, a} + {1'b0, b};
      3'b001:  alu_f = {1'b0, a} - {1'b0, b};
      3'b100:  alu_f = {1'b1, a & b};
      3'b101:  alu_f = {1'b1, a | b};
      3'b110:  alu_f = {1'b1, a ^ b};
      3'b111:  alu_f = {1'b1, ~(a | b)};
      default: alu_f = '1;
    endcase
  endfunction

  assign {aovf[0], ares[0]} = alu_f(aa[0], ab[0], aop[0]);
  assign {aovf[1], ares[1]} = alu_f(aa[1], ab[1], aop[1]);

  alu_share_ctrl #(.WIDTH(W), .OPW(OW), .SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst),
    .req0_valid(v0 & ~use_b), .req0_a(a0), .req0_b(b0), .req0_op(op0), .req0_ready(rdy0[0]),
    .resp0_valid(rv0[0]), .resp0_result(rr0[0]), .resp0_overflow(ro0[0]), .resp0_err(re0[0]),
    .req1_valid(v1 & ~use_b), .req1_a(a1), .req1_b(b1), .req1_op(op1), .req1_ready(rdy1[0]),
    .resp1_valid(rv1[0]), .resp1_result(rr1[0]), .resp1_overflow(ro1[0]), .resp1_err(re1[0]),
    .alu_a(aa[0]), .alu_b(ab[0]), .alu_op(aop[0]), .alu_result(ares[0]), .alu_overflow(aovf[0]),
    .busy(bz[0]), .grant_id(gid[0])
  );

  alu_share_ctrl #(.WIDTH(W), .OPW(OW), .SETTLE(3)) u_s3 (
    .clk(clk), .rst(rst),
    .req0_valid(v0 & use_b), .req0_a(a0), .req0_b(b0), .req0_op(op0), .req0_ready(rdy0[1]),
    .resp0_valid(rv0[1]), .resp0_result(rr0[1]), .resp0_overflow(ro0[1]), .resp0_err(re0[1]),
    .req1_valid(v1 & use_b), .req1_a(a1), .req1_b(b1), .req1_op(op1), .req1_ready(rdy1[1]),
    .resp1_valid(rv1[1]), .resp1_result(rr1[1]), .resp1_overflow(ro1[1]), .resp1_err(re1[1]),
    .alu_a(aa[1]), .alu_b(ab[1]), .alu_op(aop[1]), .alu_result(ares[1]), .alu_overflow(aovf[1]),
    .busy(bz[1]), .grant_id(gid[1])
  );

  // Selected instance view.
  logic          ready0, ready1, resp0_valid, resp1_valid, resp0_ovf, resp1_ovf, resp0_err, resp1_err;
  logic          busy, grant_id;
  logic [W-1:0]  resp0_res, resp1_res, alu_a, alu_b;
  logic [OW-1:0] alu_op;
  assign ready0      = rdy0[use_b];
  assign ready1      = rdy1[use_b];
  assign resp0_valid = rv0[use_b];
  assign resp1_valid = rv1[use_b];
  assign resp0_res   = rr0[use_b];
  assign resp1_res   = rr1[use_b];
  assign resp0_ovf   = ro0[use_b];
  assign resp1_ovf   = ro1[use_b];
  assign resp0_err   = re0[use_b];
  assign resp1_err   = re1[use_b];
  assign busy        = bz[use_b];
  assign grant_id    = gid[use_b];
  assign alu_a       = aa[use_b];
  assign alu_b       = ab[use_b];
  assign alu_op      = aop[use_b];

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every response pulse pops the next expected entry.
  always @(negedge clk) begin
    if (resp0_valid || resp1_valid) begin
      exp_t e;
      check("resp_onehot", {31'd0, resp0_valid & resp1_valid}, 32'd0);
      if (q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("resp_id", {31'd0, resp1_valid}, {31'd0, e.id});
        check("resp_result", {28'd0, resp1_valid ? resp1_res : resp0_res}, {28'd0, e.res});
        check("resp_overflow", {31'd0, resp1_valid ? resp1_ovf : resp0_ovf}, {31'd0, e.ovf});
        check("resp_err", {31'd0, resp1_valid ? resp1_err : resp0_err}, {31'd0, e.err});
      end
    end
  end

  task automatic drive(input bit id, input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [OW-1:0] op);
    if (id) begin v1 = v; a1 = a; b1 = b; op1 = op; end
    else    begin v0 = v; a0 = a; b0 = b; op0 = op; end
  endtask

  task automatic push(input bit id, input logic [W-1:0] res, input bit ovf, input bit err);
    exp_t e;
    e.id = id; e.res = res; e.ovf = ovf; e.err = err;
    q.push_back(e);
  endtask

  // Single request: bounded wait for ready, then latency and ALU-hold checks.
  task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [OW-1:0] op, input logic [W-1:0] res, input bit ovf,
                       input bit err, input int lat, output int rw);
    int n;
    bit seen;
    @(posedge clk); #1;
    drive(id, 1'b1, a, b, op);
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin
      @(negedge clk); n++;
      seen = id ? ready1 : ready0;
    end
    rw = n;
    check("ready_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      push(id, res, ovf, err);
      @(posedge clk); #1;
      drive(id, 1'b0, ~a, ~b, 3'b110);
      seen = 1'b0; n = 0;
      while (!seen && n < 20) begin
        @(negedge clk); n++;
        seen = id ? resp1_valid : resp0_valid;
        if (!seen && !err) begin
          check("alu_hold", {21'd0, alu_a, alu_b, alu_op}, {21'd0, a, b, op});
        end
      end
      check("latency", n, lat);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || q.size() != 0) && n < 30) begin
      @(negedge clk); n++;
    end
    check("drain", {31'd0, busy || q.size() != 0}, 32'd0);
  endtask

  // Simultaneous pair: req0 must win first, req1 exactly three cycles later.
  task automatic pair(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [OW-1:0] xop,
                      input logic [W-1:0] xres, input bit xovf,
                      input logic [W-1:0] ya, input logic [W-1:0] yb, input logic [OW-1:0] yop,
                      input logic [W-1:0] yres, input bit yovf);
    int n;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, xa, xb, xop);
    drive(1'b1, 1'b1, ya, yb, yop);
    @(negedge clk);
    check("pair_ready", {30'd0, ready1, ready0}, 32'd1);
    push(1'b0, xres, xovf, 1'b0);
    @(posedge clk); #1;
    v0 = 1'b0;
    n = 0;
    while (!ready1 && n < 20) begin
      @(negedge clk); n++;
    end
    check("pair_second_gap", n, 3);
    push(1'b1, yres, yovf, 1'b0);
    @(posedge clk); #1;
    v1 = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int rw;
    // Reset state, with a request pending so ready gating is exercised.
    v0 = 1'b1;
    #2;
    check("rst_outputs", {21'd0, busy, grant_id, ready0, ready1, resp0_valid, resp1_valid,
                          resp0_ovf, resp0_err, resp1_ovf, resp1_err, alu_op},
          32'd0);
    check("rst_values", {16'd0, resp0_res, resp1_res, alu_a, alu_b}, 32'd0);
    v0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: ADD 9+8 -> 1 with carry, ready in the first cycle.
    issue(1'b0, 4'h9, 4'h8, 3'b000, 4'h1, 1'b1, 1'b0, 2, rw);
    check("t1_first_cycle_ready", rw, 1);
    check("t1_resp1_untouched", {26'd0, resp1_res, resp1_ovf, resp1_err}, 32'd0);
    // 2: SUB 3-5 -> 14 with borrow.
    issue(1'b1, 4'h3, 4'h5, 3'b001, 4'hE, 1'b1, 1'b0, 2, rw);

    // 3: round-robin pairs after reset.
    do_reset();
    pair(4'hA, 4'h6, 3'b110, 4'hC, 1'b0, 4'h3, 4'h4, 3'b111, 4'h8, 1'b0);
    pair(4'h1, 4'h2, 3'b000, 4'h3, 1'b0, 4'h5, 4'hA, 3'b101, 4'hF, 1'b0);

    // 4: illegal opcode responds next cycle and leaves the ALU alone.
    issue(1'b0, 4'h7, 4'h7, 3'b010, 4'h0, 1'b0, 1'b1, 1, rw);
    check("t4_alu_unchanged", {21'd0, alu_a, alu_b, alu_op}, {21'd0, 4'h5, 4'hA, 3'b101});
    check("t4_resp1_kept", {26'd0, resp1_res, resp1_ovf, resp1_err}, {26'd0, 4'hF, 2'b00});
    issue(1'b1, 4'h1, 4'h1, 3'b011, 4'h0, 1'b0, 1'b1, 1, rw);

    // 5: reset during ISSUE drops the operation.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 4'h6, 4'h6, 3'b000);
    @(posedge clk); #1;
    v0 = 1'b0;
    check("t5_in_issue", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_clear", {13'd0, busy, grant_id, resp0_err, resp1_err, alu_a, alu_b,
                             alu_op, resp0_res}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    issue(1'b0, 4'h2, 4'h3, 3'b000, 4'h5, 1'b0, 1'b0, 2, rw);

    // 6: SETTLE=3 instance, AND F&5.
    @(posedge clk); #1;
    use_b = 1'b1;
    issue(1'b0, 4'hF, 4'h5, 3'b100, 4'h5, 1'b0, 1'b0, 4, rw);

    wait_idle();
    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
